// File: rtl/offset_sweep_pkg.sv
// Shared types for the offset sweep controller and the host-side beat capture FIFO.
package offset_sweep_pkg;

    localparam int DELAY_W = 32;
    localparam int COUNT_W = 32;
    localparam int POINT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETTLE      = 3'd1,
        ST_REQUEST     = 3'd2,
        ST_WAIT_START  = 3'd3,
        ST_WAIT_RESULT = 3'd4,
        ST_EMIT        = 3'd5
    } sweep_state_e;

    // One streamed result: the delay setting, its one-count and the final-point flag.
    typedef struct packed {
        logic [DELAY_W-1:0] delay;
        logic [COUNT_W-1:0] count;
        logic               last;
    } sweep_beat_t;

    localparam int BEAT_W = $bits(sweep_beat_t);

    // True when index addresses the final point of a sweep of npts points (npts >= 1).
    function automatic logic is_last_point(input logic [POINT_W-1:0] index,
                                           input logic [POINT_W-1:0] npts);
        return index == (npts - POINT_W'(1));
    endfunction

endpackage

// File: rtl/offset_sweep_controller.sv
// Sweeps the sampler delay across N points, runs one sampling pass per point and
// streams each {delay, one_count, last} beat out on a valid/ready interface.
//
// state          | meaning
// ---------------+------------------------------------------------------------
// ST_IDLE        | waiting for start; parameters latched on accepted start
// ST_SETTLE      | clock generator retuning after a delay change
// ST_REQUEST     | raise request_run towards the sampler
// ST_WAIT_START  | request_run held until the sampler reports running
// ST_WAIT_RESULT | sampler busy; waiting for its result_ready pulse
// ST_EMIT        | beat presented downstream until accepted
module offset_sweep_controller
    import offset_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DELAY_W-1:0]  delay_start,
    input  logic [DELAY_W-1:0]  delay_step,
    input  logic [POINT_W-1:0]  point_count,
    output logic [DELAY_W-1:0]  delay_out,
    output logic                request_run,
    input  logic                sampler_running,
    input  logic                sampler_result_ready,
    input  logic [COUNT_W-1:0]  sampler_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DELAY_W-1:0]  out_delay,
    output logic [COUNT_W-1:0]  out_count,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                timeout_error
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    sweep_state_e             state_q,  state_d;
    logic [SETTLE_W-1:0]      settle_q, settle_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q,     wd_d;
    logic [POINT_W-1:0]       index_q,  index_d;
    logic [POINT_W-1:0]       npts_q,   npts_d;
    logic [DELAY_W-1:0]       delay_q,  delay_d;
    logic [DELAY_W-1:0]       step_q,   step_d;
    sweep_beat_t              beat_q,   beat_d;
    logic                     valid_q,  valid_d;
    logic                     req_q,    req_d;
    logic                     done_q,   done_d;
    logic                     terr_q,   terr_d;
    logic                     busy_q,   busy_d;

    // Next-state and next-output logic; abort from any active state wins over everything.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        wd_d     = wd_q;
        index_d  = index_q;
        npts_d   = npts_q;
        delay_d  = delay_q;
        step_d   = step_q;
        beat_d   = beat_q;
        valid_d  = valid_q;
        req_d    = req_q;
        done_d   = 1'b0;
        terr_d   = terr_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        npts_d  = point_count;
                        step_d  = delay_step;
                        delay_d = delay_start;
                        index_d = '0;
                        terr_d  = 1'b0;
                        if (point_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            settle_d = SETTLE_LOAD;
                            state_d  = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = ST_REQUEST;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_REQUEST: begin
                    req_d   = 1'b1;
                    wd_d    = '0;
                    state_d = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    wd_d = wd_q + TIMEOUT_WIDTH'(1);
                    if (sampler_running) begin
                        // Dropping request_run here keeps the sampler from rearming on return.
                        req_d   = 1'b0;
                        state_d = ST_WAIT_RESULT;
                    end else if (wd_q == '1) begin
                        req_d   = 1'b0;
                        terr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_RESULT: begin
                    wd_d = wd_q + TIMEOUT_WIDTH'(1);
                    if (sampler_result_ready) begin
                        beat_d.delay = delay_q;
                        beat_d.count = sampler_result;
                        beat_d.last  = is_last_point(index_q, npts_q);
                        valid_d      = 1'b1;
                        state_d      = ST_EMIT;
                    end else if (wd_q == '1) begin
                        terr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        if (beat_q.last) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            index_d  = index_q + POINT_W'(1);
                            delay_d  = delay_q + step_q;
                            settle_d = SETTLE_LOAD;
                            state_d  = ST_SETTLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            wd_q     <= '0;
            index_q  <= '0;
            npts_q   <= '0;
            delay_q  <= '0;
            step_q   <= '0;
            beat_q   <= '0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            wd_q     <= wd_d;
            index_q  <= index_d;
            npts_q   <= npts_d;
            delay_q  <= delay_d;
            step_q   <= step_d;
            beat_q   <= beat_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            busy_q   <= busy_d;
        end
    end

    assign delay_out     = delay_q;
    assign request_run   = req_q;
    assign out_valid     = valid_q;
    assign out_delay     = beat_q.delay;
    assign out_count     = beat_q.count;
    assign out_last      = beat_q.last;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_error = terr_q;

endmodule

// File: doc/offset_sweep_controller.md
Name: offset_sweep_controller

Overview:
- Initiator for offset_sampler's run/result handshake: sweeps the ETS delay setting across N points and runs one sampling pass per point.
- Streams each {delay, one_count} pair out on a valid/ready interface.
- Sits between the host register block and offset_sampler; drives the sampler's request_run and delay_characteristics_in, consumes running / result_ready / result.

Parameters:
SETTLE_CYCLES, 16, cycles to wait after changing delay_out before requesting a run (clkgen retune time); must be >= 1
TIMEOUT_WIDTH, 24, width of watchdog counter; a run exceeding 2^TIMEOUT_WIDTH-1 cycles is aborted

Ports:
clk  in  1  system clock (same domain as offset_sampler clk)
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a sweep when idle, ignored when busy
abort  in  1  level/pulse; terminates the sweep from any state
delay_start  in  32  delay setting for point 0; sampled on accepted start
delay_step  in  32  increment between points; sampled on accepted start
point_count  in  16  number of points; sampled on accepted start
delay_out  out  32  to sampler delay_characteristics_in
request_run  out  1  to sampler request_run
sampler_running  in  1  from sampler running
sampler_result_ready  in  1  from sampler result_ready (one-cycle pulse)
sampler_result  in  32  from sampler result
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts beat
out_delay  out  32  delay setting of this beat
out_count  out  32  one-count of this beat
out_last  out  1  beat is final point of sweep
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on sweep completion, abort or timeout
timeout_error  out  1  sticky; set on watchdog expiry, cleared on next accepted start

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; internal counters 0.
- All outputs registered.
- States: IDLE, SETTLE, REQUEST, WAIT_START, WAIT_RESULT, EMIT.
- IDLE: on start, latch the three inputs, delay_out<=delay_start, index<=0, clear timeout_error.
  - If point_count==0: pulse done next cycle, stay IDLE, no run issued.
  - Otherwise go to SETTLE with settle counter loaded to SETTLE_CYCLES-1.
- SETTLE: count down; at 0 go to REQUEST.
- REQUEST: assert request_run; go to WAIT_START; clear watchdog.
- WAIT_START: hold request_run high until sampler_running==1 is seen, then drop request_run (same edge) and go to WAIT_RESULT.
  - request_run must be low before the sampler returns to its wait state, so no back-to-back rerun occurs.
- WAIT_RESULT: on sampler_result_ready, capture sampler_result into out_count and delay_out into out_delay; set out_last = (index==point_count-1); go to EMIT with out_valid=1.
  - A result_ready seen in any other state is ignored.
- EMIT: hold out_valid/out_delay/out_count/out_last stable until out_valid&&out_ready.
  - On handshake, out_valid<=0.
  - If last: pulse done, go IDLE.
  - Else: index+1, delay_out<=delay_out+delay_step (mod 2^32, wrap silently), go to SETTLE.
- Latency per point, excluding sampler run time: SETTLE_CYCLES + 1 (REQUEST) + handshake wait.
- Watchdog: counts every cycle in WAIT_START/WAIT_RESULT. At all-ones: set timeout_error, drop request_run, pulse done, go IDLE, emit nothing for that point.
- abort: highest priority, from any non-IDLE state.
  - Next cycle: IDLE, request_run=0, out_valid=0 (pending beat dropped), done pulse.
  - abort in IDLE has no effect and no done pulse.
  - abort and start in the same cycle while IDLE: start is ignored.
- start while busy: ignored; latched parameters are unaffected.
- Reset mid-sweep: immediate return to IDLE with outputs 0. The sampler may still finish its run; the stray result_ready is ignored.

Decomposition:
- Shared package offset_sweep_pkg: state encoding localparams, and a beat struct/width constant {delay 32, count 32, last 1} reused by the host-side capture FIFO.
- No sub-module required. Optional: the watchdog counter as a small generic sat_counter if one already exists.

Test Plan:
- Basic sweep: delay_start=100, delay_step=5, point_count=3, sampler model returns count=delay/10 → beats (100,10,0),(105,10,0),(110,11,1); one done pulse; request_run never high when sampler_running seen low after run start.
- Backpressure: out_ready low for 20 cycles on beat 2 → beat held stable, no further request_run until handshake, delay_out unchanged.
- Zero points: point_count=0, start → done pulse 1 cycle later, request_run never asserted, no beats.
- Wrap: delay_start=32'hFFFFFFFE, delay_step=3, point_count=2 → out_delay FFFFFFFE then 00000001.
- Timeout: TIMEOUT_WIDTH=4, sampler never raises result_ready → after 15 cycles timeout_error=1, done pulse, busy=0; next start clears timeout_error.
- Abort mid-run: abort during WAIT_RESULT, then late result_ready from sampler → no beat emitted, done pulse on abort only, state IDLE.
